// File: rtl/log_dump_controller.sv
// Drains the signal-log FIFO to a byte-wide UART: each word goes out MSB byte first,
// followed by a 0x0A terminator. Also sequences FIFO flushes, on request or after a dump.
module log_dump_controller #(
  parameter int DATA_WIDTH   = 32,
  parameter int WAIT_LIMIT   = 4,
  parameter int MAX_ENTRIES  = 256,
  parameter int FLUSH_CYCLES = 256,
  parameter bit AUTO_FLUSH   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dump_req,
  input  logic                  clear_req,
  input  logic                  log_empty,
  input  logic                  line_trans_en,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  tx_busy,
  output logic                  read_en,
  output logic                  line_transmitted,
  output logic                  flush,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  output logic                  dump_active,
  output logic                  dump_done,
  output logic [15:0]           line_count
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int EW    = $clog2(MAX_ENTRIES + 1);
  localparam int WW    = $clog2(WAIT_LIMIT + 1);
  localparam int BW    = $clog2(BYTES + 1);

  localparam logic [EW-1:0] ENTRY_MAX  = EW'(MAX_ENTRIES);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(WAIT_LIMIT - 1);
  localparam logic [BW-1:0] BYTE_TERM  = BW'(BYTES);
  localparam logic [8:0]    FLUSH_LAST = 9'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DATA = 3'd2,
    SEND_BYTE = 3'd3,
    WAIT_TX   = 3'd4,
    DONE      = 3'd5,
    FLUSH     = 3'd6
  } state_t;

  state_t                state_r;
  logic [EW-1:0]         entry_cnt_r;
  logic [WW-1:0]         wait_cnt_r;
  logic [BW-1:0]         byte_idx_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [8:0]            flush_cnt_r;
  logic                  tx_skip_r;
  logic                  end_of_dump_s;

  assign end_of_dump_s = log_empty || (entry_cnt_r == ENTRY_MAX);

  // Controller FSM; every output is a register set on the transition into its state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r          <= IDLE;
      entry_cnt_r      <= '0;
      wait_cnt_r       <= '0;
      byte_idx_r       <= '0;
      shift_r          <= '0;
      flush_cnt_r      <= 9'd0;
      tx_skip_r        <= 1'b0;
      read_en          <= 1'b0;
      line_transmitted <= 1'b0;
      flush            <= 1'b0;
      tx_data          <= 8'h00;
      tx_start         <= 1'b0;
      dump_active      <= 1'b0;
      dump_done        <= 1'b0;
      line_count       <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (clear_req) begin
            state_r     <= FLUSH;
            flush       <= 1'b1;
            flush_cnt_r <= 9'd0;
            dump_active <= 1'b1;
          end else if (dump_req) begin
            line_count  <= 16'd0;
            entry_cnt_r <= '0;
            dump_active <= 1'b1;
            if (log_empty) begin
              state_r   <= DONE;
              dump_done <= 1'b1;
            end else begin
              state_r          <= ISSUE;
              read_en          <= 1'b1;
              line_transmitted <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          read_en          <= 1'b0;
          line_transmitted <= 1'b0;
          entry_cnt_r      <= entry_cnt_r + EW'(1);
          wait_cnt_r       <= '0;
          state_r          <= WAIT_DATA;
        end
        WAIT_DATA: begin
          if (line_trans_en) begin
            shift_r    <= read_data;
            byte_idx_r <= '0;
            state_r    <= SEND_BYTE;
          end else if (wait_cnt_r == WAIT_LAST) begin
            // No data in time: the entry counts as issued but produces no line.
            if (end_of_dump_s) begin
              state_r   <= DONE;
              dump_done <= 1'b1;
            end else begin
              state_r          <= ISSUE;
              read_en          <= 1'b1;
              line_transmitted <= 1'b1;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + WW'(1);
          end
        end
        SEND_BYTE: begin
          if (!tx_busy) begin
            tx_start  <= 1'b1;
            tx_data   <= (byte_idx_r == BYTE_TERM) ? 8'h0A : shift_r[DATA_WIDTH-1 -: 8];
            tx_skip_r <= 1'b1;
            state_r   <= WAIT_TX;
          end else begin
            state_r <= SEND_BYTE;
          end
        end
        WAIT_TX: begin
          tx_start <= 1'b0;
          // The UART raises tx_busy one cycle late, so the first cycle here is blind.
          if (tx_skip_r) begin
            tx_skip_r <= 1'b0;
          end else if (!tx_busy) begin
            if (byte_idx_r != BYTE_TERM) begin
              shift_r    <= {shift_r[DATA_WIDTH-9:0], 8'h00};
              byte_idx_r <= byte_idx_r + BW'(1);
              state_r    <= SEND_BYTE;
            end else begin
              if (line_count != 16'hFFFF) begin
                line_count <= line_count + 16'd1;
              end else begin
                line_count <= line_count;
              end
              if (end_of_dump_s) begin
                state_r   <= DONE;
                dump_done <= 1'b1;
              end else begin
                state_r          <= ISSUE;
                read_en          <= 1'b1;
                line_transmitted <= 1'b1;
              end
            end
          end else begin
            state_r <= WAIT_TX;
          end
        end
        DONE: begin
          dump_done <= 1'b0;
          if (AUTO_FLUSH) begin
            state_r     <= FLUSH;
            flush       <= 1'b1;
            flush_cnt_r <= 9'd0;
          end else begin
            state_r     <= IDLE;
            dump_active <= 1'b0;
          end
        end
        FLUSH: begin
          if (flush_cnt_r == FLUSH_LAST) begin
            flush       <= 1'b0;
            dump_active <= 1'b0;
            state_r     <= IDLE;
          end else begin
            flush_cnt_r <= flush_cnt_r + 9'd1;
          end
        end
        default: begin
          state_r          <= IDLE;
          read_en          <= 1'b0;
          line_transmitted <= 1'b0;
          flush            <= 1'b0;
          tx_start         <= 1'b0;
          dump_active      <= 1'b0;
          dump_done        <= 1'b0;
        end
      endcase
    end
  end

endmodule
